f_pc_fetch: RTL and testbench

- Fetch-stage program counter unit. Sits directly downstream of the decode-stage branch comparator.
- Consumes the branch-taken flag plus decode-stage jump controls and produces the next fetch address.
- Drives a valid/ready request interface to instruction memory.
- Implements MIPS single delay-slot semantics: a redirect decided in D applies to the fetch after the delay slot.

---
 rtl/f_pc_fetch.sv | 161 ++++++++++++++++
 tb/tb_f_pc_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/f_pc_fetch.sv
// ============================================================================
// Module   : f_pc_fetch
// Desc     : Fetch-stage PC unit with MIPS single delay-slot redirect and a
//            valid/ready instruction-memory request. Optional redirect
//            counter enabled by macro F_REDIRECT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_d_valid,
  input  logic              i_con_ifbranch,
  input  logic [1:0]        i_con_jump,
  input  logic [ADDR_W-1:0] i_d_pc_plus4,
  input  logic [15:0]       i_branch_imm,
  input  logic [25:0]       i_jump_index,
  input  logic [ADDR_W-1:0] i_data_rs,
  input  logic              i_imem_ready,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4
`ifdef F_REDIRECT_CNT_EN
  ,
  output logic [31:0]       o_redirect_cnt
`endif
);

  localparam logic [1:0] c_jump_none  = 2'b00;
  localparam logic [1:0] c_jump_index = 2'b01;
  localparam logic [1:0] c_jump_reg   = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_pend;
  logic [ADDR_W-1:0] w_pend_nxt;
  logic              w_req;
  logic              w_accept;
  logic              w_capture;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_j_target;
  logic [ADDR_W-1:0] w_jr_target;
  logic              w_unused_rs_low;

  // jr/jalr targets are word aligned; the low rs bits are dropped on purpose.
  assign w_unused_rs_low = ^i_data_rs[1:0];

  assign w_br_target = i_d_pc_plus4 + {{(ADDR_W-18){i_branch_imm[15]}}, i_branch_imm, 2'b00};
  assign w_j_target  = {i_d_pc_plus4[ADDR_W-1:ADDR_W-4], i_jump_index, 2'b00};
  assign w_jr_target = {i_data_rs[ADDR_W-1:2], 2'b00};

  assign w_redirect = i_d_valid & ~i_stall &
                      (i_con_ifbranch | (i_con_jump == c_jump_index) |
                       (i_con_jump == c_jump_reg));

  always_comb begin
    w_target = w_br_target;
    if (i_con_jump == c_jump_reg) begin
      w_target = w_jr_target;
    end else if (i_con_jump == c_jump_index) begin
      w_target = w_j_target;
    end else if (i_con_jump == c_jump_none) begin
      w_target = w_br_target;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_req       = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_req     = 1'b1;
        w_accept  = i_imem_ready & ~i_stall;
        w_capture = w_redirect;
        if (w_redirect) begin
          // Delay slot is the word being fetched now; the target follows it.
          if (w_accept) begin
            w_pc_nxt = w_target;
          end else begin
            w_pend_nxt  = w_target;
            w_state_nxt = ST_HOLD;
          end
        end else if (w_accept) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      ST_HOLD: begin
        w_req    = 1'b1;
        w_accept = i_imem_ready & ~i_stall;
        if (w_accept) begin
          w_pc_nxt    = r_pend;
          w_pend_nxt  = '0;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

`ifdef F_REDIRECT_CNT_EN
  logic [31:0] r_redirect_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_redirect_cnt <= '0;
    end else if (w_capture && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
      r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign o_redirect_cnt = r_redirect_cnt;
`else
  logic w_unused_capture;
  assign w_unused_capture = w_capture;
`endif

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_pc_plus4  = r_pc + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_f_pc_fetch.sv
// ============================================================================
// Module   : tb_f_pc_fetch
// Desc     : Self-checking bench for f_pc_fetch: per-cycle behavioural model
//            plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_f_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        d_valid = 1'b0;
  logic        br = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic [31:0] pc4 = '0;
  logic [15:0] imm = '0;
  logic [25:0] idx = '0;
  logic [31:0] rs = '0;
  logic        ready = 1'b1;
  logic        req;
  logic [31:0] addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef F_REDIRECT_CNT_EN
  logic [31:0] rcnt;
`endif

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  f_pc_fetch #(.RESET_PC(RESET_PC), .ADDR_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_d_valid(d_valid),
    .i_con_ifbranch(br), .i_con_jump(jump), .i_d_pc_plus4(pc4),
    .i_branch_imm(imm), .i_jump_index(idx), .i_data_rs(rs),
    .i_imem_ready(ready), .o_imem_req(req), .o_imem_addr(addr),
    .o_pc(pc), .o_pc_plus4(pc_plus4)
`ifdef F_REDIRECT_CNT_EN
    , .o_redirect_cnt(rcnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: "fetching" flag, the current PC and at most one
  // outstanding redirect target waiting for its delay slot to be fetched.
  bit          m_fetching;
  logic [31:0] m_pc;
  logic [31:0] m_pending[$];
  int unsigned m_cnt;

  function automatic logic [31:0] model_target();
    if (jump == 2'b10) return rs & 32'hFFFF_FFFC;
    if (jump == 2'b01) return (pc4 & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
    return pc4 + 32'($signed(imm)) * 32'd4;
  endfunction

  always @(negedge rst_n) begin
    m_fetching = 1'b0;
    m_pc       = RESET_PC;
    m_pending.delete();
    m_cnt      = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit take, redir;
      take  = m_fetching && ready && !stall;
      redir = m_fetching && m_pending.size() == 0 && d_valid && !stall &&
              (br || jump == 2'b01 || jump == 2'b10);
      if (!m_fetching) begin
        m_fetching = 1'b1;
      end else if (m_pending.size() != 0) begin
        if (take) m_pc = m_pending.pop_front();
      end else if (redir) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (take) m_pc = model_target();
        else m_pending.push_back(model_target());
      end else if (take) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_req", {31'd0, req}, {31'd0, m_fetching});
      check("model_pc", pc, m_pc);
      check("model_addr", addr, m_pc);
      check("model_pc_plus4", pc_plus4, m_pc + 32'd4);
`ifdef F_REDIRECT_CNT_EN
      check("model_redirect_cnt", rcnt, m_cnt);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    d_valid = 1'b0; br = 1'b0; jump = 2'b00; stall = 1'b0;
  endtask

  initial begin
    m_fetching = 1'b0;
    m_pc = RESET_PC;
    m_cnt = 0;
    cyc(); cyc();
    check("reset_pc", pc, RESET_PC);
    check("reset_req", {31'd0, req}, 32'd0);
    rst_n = 1'b1;
    model_on = 1'b1;
    #1;
    check("boot_req_low", {31'd0, req}, 32'd0);
    cyc();
    check("run_req_high", {31'd0, req}, 32'd1);
    check("pc0", pc, 32'hBFC0_0000);
    cyc(); check("pc1", pc, 32'hBFC0_0004);
    cyc(); check("pc2", pc, 32'hBFC0_0008);

    // Taken branch accepted in the same cycle as its delay slot.
    d_valid = 1; br = 1; pc4 = 32'h0040_0010; imm = 16'hFFFC;
    cyc(); clr();
    check("branch_target", pc, 32'h0040_0000);

    // j with memory not ready for three cycles.
    ready = 0; d_valid = 1; jump = 2'b01; pc4 = 32'h1000_0004; idx = 26'h0000100;
    cyc(); clr();
    cyc(); cyc();
    check("j_hold_delay_slot", pc, 32'h0040_0000);
    check("j_hold_req", {31'd0, req}, 32'd1);
    ready = 1;
    cyc();
    check("j_target", pc, 32'h1000_0400);

    // jr beats a simultaneous branch; low rs bits are cleared.
    d_valid = 1; jump = 2'b10; br = 1; rs = 32'h0040_1237; pc4 = 32'h1000_0404; imm = 16'h0010;
    cyc(); clr();
    check("jr_target", pc, 32'h0040_1234);

    // Stall during a taken branch: nothing moves until release.
    stall = 1; d_valid = 1; br = 1; pc4 = 32'h0040_1238; imm = 16'h0004;
    cyc(); cyc();
    check("stall_pc_hold", pc, 32'h0040_1234);
    stall = 0;
    cyc(); clr();
    check("stall_release_target", pc, 32'h0040_1248);

    // Reserved jump code behaves as no jump.
    d_valid = 1; jump = 2'b11;
    cyc(); clr();
    check("jump_reserved", pc, 32'h0040_124C);

    // Redirect arriving in HOLD is ignored.
    ready = 0; d_valid = 1; br = 1; pc4 = 32'h0000_2000; imm = 16'h0040;
    cyc(); clr();
    d_valid = 1; jump = 2'b01; idx = 26'h3FFFFFF;
    cyc(); clr();
    ready = 1;
    cyc();
    check("hold_ignores_second", pc, 32'h0000_2100);

    // Wrap-around of the sequential increment.
    d_valid = 1; jump = 2'b10; rs = 32'hFFFF_FFFE;
    cyc(); clr();
    check("pc_at_top", pc, 32'hFFFF_FFFC);
    cyc();
    check("pc_wrap", pc, 32'h0000_0000);

    // Asynchronous reset while a redirect is pending.
    ready = 0; d_valid = 1; br = 1; pc4 = 32'h0000_0004; imm = 16'h0100;
    cyc(); clr();
    #2;
    rst_n = 0;
    #1;
    check("async_reset_pc", pc, RESET_PC);
    check("async_reset_req", {31'd0, req}, 32'd0);
    ready = 1;
    cyc();
    rst_n = 1;
    cyc(); cyc();
    check("pending_discarded", pc, 32'hBFC0_0004);
    cyc();
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
